// File: rtl/tone_pkg.sv
// Shared types and constants for the square-wave tone generator.
package tone_pkg;
  localparam int CNT_W_DEF  = 32;
  localparam int DATA_W_DEF = 24;

  localparam logic [23:0] SAT_POS = 24'h7FFFFF;
  localparam logic [23:0] SAT_NEG = 24'h800000;

  typedef enum logic [1:0] {IDLE, PEND, WRITE} tone_state_t;
endpackage

// File: rtl/half_period_div.sv
// Square-wave phase generator: toggles phase every hp_q clocks, restarts cleanly on tone change.
module half_period_div
  import tone_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] half_period,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp_q;

  // The >= compare also recovers when the period shrinks below cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      hp_q  <= '0;
      phase <= 1'b0;
    end else if (half_period != hp_q) begin
      hp_q  <= half_period;
      cnt   <= '0;
      phase <= 1'b1;
    end else if (hp_q == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt >= hp_q - 1'b1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tone_square_gen.sv
// Square-wave audio source: paces samples at SAMPLE_DIV and hands them to the codec FIFO.
module tone_square_gen
  import tone_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [DATA_W-1:0] level_l,
  input  logic [DATA_W-1:0] level_r,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              phase,
  output logic [7:0]        drop_cnt
);

  localparam int NUM_CH = 2;
  localparam int SC_W   = $clog2(SAMPLE_DIV);
  localparam logic [DATA_W-1:0] S_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  tone_state_t state, state_d;
  logic        tick_pend, pend_d;
  logic        tick, latch, drop;
  logic        hp_zero;
  logic [SC_W-1:0] scnt;

  logic [NUM_CH-1:0][DATA_W-1:0] level_v, samp_v, samp_q;

  half_period_div #(.CNT_W(CNT_W)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .half_period (half_period),
    .phase       (phase)
  );

  // hp_q inside the divider always equals last cycle's half_period, so a
  // one-bit shadow of its zero test is enough for the silence decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hp_zero <= 1'b1;
    else        hp_zero <= (half_period == '0);
  end

  assign tick = (scnt == SC_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    scnt <= '0;
    else if (tick) scnt <= '0;
    else           scnt <= scnt + 1'b1;
  end

  assign level_v = {level_r, level_l};

  // Low phase negates; the most negative level would overflow, so clamp it.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign samp_v[c] = hp_zero ? '0 :
                       phase   ? level_v[c] :
                       (level_v[c] == S_NEG) ? S_POS : -level_v[c];
  end

  always_comb begin
    state_d = state;
    pend_d  = tick_pend;
    latch   = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          latch   = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (tick) begin
          latch = 1'b1;
          drop  = 1'b1;
        end else if (audio_out_allowed) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // A tick seen here is consumed on the way out, so the data under the strobe stays put.
        if (tick_pend || tick) begin
          latch   = 1'b1;
          pend_d  = 1'b0;
          state_d = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_pend <= 1'b0;
      samp_q    <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_d;
      tick_pend <= pend_d;
      if (latch) samp_q <= samp_v;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign write_audio_out = (state == WRITE);
  assign left_out        = samp_q[0];
  assign right_out       = samp_q[1];

endmodule

// File: tb/tb_tone_square_gen.sv
// Directed bench for tone_square_gen with SAMPLE_DIV=4.
module tb_tone_square_gen;

  localparam int CNT_W  = 32;
  localparam int DATA_W = 24;

  logic              clk;
  logic              rst_n;
  logic [CNT_W-1:0]  half_period;
  logic [DATA_W-1:0] level_l, level_r;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [DATA_W-1:0] left_out, right_out;
  logic              phase;
  logic [7:0]        drop_cnt;

  int tests_run;
  int tests_failed;

  tone_square_gen #(.CNT_W(CNT_W), .DATA_W(DATA_W), .SAMPLE_DIV(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .half_period       (half_period),
    .level_l           (level_l),
    .level_r           (level_r),
    .audio_out_allowed (audio_out_allowed),
    .write_audio_out   (write_audio_out),
    .left_out          (left_out),
    .right_out         (right_out),
    .phase             (phase),
    .drop_cnt          (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs must already be set; returns just after the negedge where rst_n rose.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_ph;
    half_period = 3; level_l = 24'h123456; level_r = 24'h000777; audio_out_allowed = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({write_audio_out, phase, left_out, right_out, drop_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wr=%b ph=%b l=%h r=%h drop=%0d expected all 0",
               write_audio_out, phase, left_out, right_out, drop_cnt);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_ph = (((k - 1) / 3) % 2) == 0;
      tests_run++;
      if (phase !== exp_ph) begin
        tests_failed++;
        $display("FAIL reset_phase k=%0d: got %b expected %b", k, phase, exp_ph);
      end
    end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp_l [6];
    logic exp_w;
    exp_l = '{24'h100000, 24'h100000, 24'hF00000, 24'h100000, 24'h100000, 24'hF00000};
    half_period = 3; level_l = 24'h100000; level_r = '0; audio_out_allowed = 1'b1;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_w = (k >= 5) && (k % 4 == 1);
      tests_run++;
      if (write_audio_out !== exp_w) begin
        tests_failed++;
        $display("FAIL stream_write k=%0d: got %b expected %b", k, write_audio_out, exp_w);
      end
      if (exp_w) begin
        tests_run++;
        if (left_out !== exp_l[(k-5)/4] || right_out !== 24'h0) begin
          tests_failed++;
          $display("FAIL stream_data k=%0d: got l=%h r=%h expected l=%h r=000000",
                   k, left_out, right_out, exp_l[(k-5)/4]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    half_period = 3; level_l = 24'h100000; level_r = '0; audio_out_allowed = 1'b0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests_run++;
      if (write_audio_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_nowrite k=%0d: got %b expected 0", k, write_audio_out);
      end
    end
    audio_out_allowed = 1'b1;
    @(negedge clk);
    tests_run++;
    if (write_audio_out !== 1'b1 || left_out !== 24'hF00000 || drop_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL bp_release: got wr=%b l=%h drop=%0d expected wr=1 l=f00000 drop=2",
               write_audio_out, left_out, drop_cnt);
    end
    @(negedge clk);
    tests_run++;
    if (write_audio_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_single: got %b expected 0", write_audio_out);
    end
  endtask

  task automatic test_tone_change();
    logic exp_ph [6:20];
    exp_ph = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    half_period = 5; level_l = 24'h100000; level_r = 24'h000123; audio_out_allowed = 1'b1;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tests_run++;
      if (phase !== ((k <= 5) ? 1'b1 : exp_ph[k])) begin
        tests_failed++;
        $display("FAIL tone_phase k=%0d: got %b expected %b", k, phase,
                 (k <= 5) ? 1'b1 : exp_ph[k]);
      end
      if (k == 17) begin
        tests_run++;
        if (write_audio_out !== 1'b1 || left_out !== '0 || right_out !== '0) begin
          tests_failed++;
          $display("FAIL tone_silence: got wr=%b l=%h r=%h expected wr=1 l=0 r=0",
                   write_audio_out, left_out, right_out);
        end
      end
      if (k == 5)  half_period = 2;
      if (k == 12) half_period = 0;
    end
  endtask

  task automatic test_saturation();
    half_period = 3; level_l = 24'h800000; level_r = 24'h000010; audio_out_allowed = 1'b1;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 9) begin
        tests_run++;
        if (write_audio_out !== 1'b1 || left_out !== 24'h800000 || right_out !== 24'h000010) begin
          tests_failed++;
          $display("FAIL sat_high: got wr=%b l=%h r=%h expected wr=1 l=800000 r=000010",
                   write_audio_out, left_out, right_out);
        end
      end
      if (k == 13) begin
        tests_run++;
        if (write_audio_out !== 1'b1 || left_out !== 24'h7FFFFF || right_out !== 24'hFFFFF0) begin
          tests_failed++;
          $display("FAIL sat_low: got wr=%b l=%h r=%h expected wr=1 l=7fffff r=fffff0",
                   write_audio_out, left_out, right_out);
        end
      end
    end
  endtask

  task automatic test_reset_in_pend();
    half_period = 3; level_l = 24'h100000; level_r = '0; audio_out_allowed = 1'b0;
    do_reset();
    repeat (9) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL rip_pre_drop: got %0d expected 1", drop_cnt);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (write_audio_out !== 1'b0 || drop_cnt !== 8'd0 || left_out !== '0) begin
      tests_failed++;
      $display("FAIL rip_async: got wr=%b drop=%0d l=%h expected 0/0/0",
               write_audio_out, drop_cnt, left_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    audio_out_allowed = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (write_audio_out !== (k == 5)) begin
        tests_failed++;
        $display("FAIL rip_write k=%0d: got %b expected %b", k, write_audio_out, (k == 5));
      end
    end
    tests_run++;
    if (left_out !== 24'h100000 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL rip_data: got l=%h drop=%0d expected l=100000 drop=0", left_out, drop_cnt);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; half_period = '0; level_l = '0; level_r = '0; audio_out_allowed = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_tone_change();
    test_saturation();
    test_reset_in_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
